// File: rtl/serial_tx.sv
// serial_tx: 2-wire synchronous serial transmitter (serial_clk + serial_data), 10-bit words MSB first.
// Define SERIAL_TX_PARITY_EN to append an even-parity frame after bit 9 (11 serial_clk rises per word).
module serial_tx #(
  parameter int DATA_W  = 10,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              serial_clk,
  output logic              serial_data
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam logic [7:0] PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_W - 1);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
      $error("serial_tx: CLK_DIV must be in 2..255");
    end
    if (DATA_W != 10) begin : g_bad_width
      $error("serial_tx: DATA_W is fixed at 10");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t             state;
  logic [7:0]         phase_cnt;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] shift_reg;
  logic [FRAME_W-1:0] load_frame;

  // The parity frame simply rides at the bottom of the shift register.
`ifdef SERIAL_TX_PARITY_EN
  assign load_frame = {data_in, ^data_in};
`else
  assign load_frame = data_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      serial_clk  <= 1'b0;
      serial_data <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!enable) begin
        // Abort: drop the word silently, no done pulse.
        state       <= IDLE;
        phase_cnt   <= '0;
        bit_cnt     <= '0;
        shift_reg   <= '0;
        busy        <= 1'b0;
        serial_clk  <= 1'b0;
        serial_data <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              shift_reg   <= load_frame;
              serial_data <= load_frame[FRAME_W-1];
              state       <= LOW;
              busy        <= 1'b1;
              phase_cnt   <= '0;
              bit_cnt     <= '0;
            end
          end
          LOW: begin
            if (phase_cnt == PH_LAST) begin
              phase_cnt  <= '0;
              state      <= HIGH;
              serial_clk <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end
          HIGH: begin
            if (phase_cnt == PH_LAST) begin
              phase_cnt  <= '0;
              serial_clk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state       <= IDLE;
                busy        <= 1'b0;
                done        <= 1'b1;
                serial_data <= 1'b0;
                bit_cnt     <= '0;
                shift_reg   <= '0;
              end else begin
                // Next bit goes out on the falling edge of serial_clk.
                state       <= LOW;
                bit_cnt     <= bit_cnt + 4'd1;
                shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
                serial_data <= shift_reg[FRAME_W-2];
              end
            end else begin
              phase_cnt <= phase_cnt + 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (CLK_DIV 2, 3, 8) with a behavioural receiver sampling on serial_clk rises.
module tb_serial_tx;
  localparam int NI = 3;
  localparam int DIVS [NI] = '{2, 3, 8};
`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAMES = 11;
`else
  localparam int FRAMES = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_v [NI];
  logic       start_v  [NI];
  logic [9:0] data_v   [NI];
  logic       busy_v   [NI];
  logic       done_v   [NI];
  logic       sclk_v   [NI];
  logic       sdata_v  [NI];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      serial_tx #(.DATA_W(10), .CLK_DIV(DIVS[gi])) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable_v[gi]),
        .start      (start_v[gi]),
        .data_in    (data_v[gi]),
        .busy       (busy_v[gi]),
        .done       (done_v[gi]),
        .serial_clk (sclk_v[gi]),
        .serial_data(sdata_v[gi])
      );
    end
  endgenerate

  // Receiver model: shift in serial_data at every serial_clk rise, latch the word on done.
  logic [10:0] acc        [NI];
  int          rises      [NI];
  logic [10:0] last_word  [NI];
  int          last_rises [NI];
  int          done_cnt   [NI] = '{0, 0, 0};
  int          viol       [NI] = '{0, 0, 0};
  logic        prev_sclk  [NI];
  logic        prev_sdata [NI];
  logic        prev_busy  [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        acc[i]        <= '0;
        rises[i]      <= 0;
        last_word[i]  <= '0;
        last_rises[i] <= 0;
        prev_sclk[i]  <= 1'b0;
        prev_sdata[i] <= 1'b0;
        prev_busy[i]  <= 1'b0;
      end else begin
        if (sclk_v[i] && !prev_sclk[i]) begin
          acc[i]   <= {acc[i][9:0], sdata_v[i]};
          rises[i] <= rises[i] + 1;
        end
        // Data may only move when serial_clk falls.
        if (busy_v[i] && prev_busy[i] && (sdata_v[i] !== prev_sdata[i]) && !(prev_sclk[i] && !sclk_v[i]))
          viol[i] <= viol[i] + 1;
        if (done_v[i]) begin
          last_word[i]  <= acc[i];
          last_rises[i] <= rises[i];
          done_cnt[i]   <= done_cnt[i] + 1;
        end
        if (!busy_v[i]) begin
          acc[i]   <= '0;
          rises[i] <= 0;
        end
        prev_sclk[i]  <= sclk_v[i];
        prev_sdata[i] <= sdata_v[i];
        prev_busy[i]  <= busy_v[i];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected received frame: the word MSB first, plus even parity when enabled.
  function automatic logic [10:0] exp_frame(input logic [9:0] d);
    logic p;
    p = 1'($countones(d) % 2);
    if (FRAMES == 11) return {d, p};
    return {1'b0, d};
  endfunction

  task automatic kick(input int i, input logic [9:0] d);
    start_v[i] = 1'b1;
    data_v[i]  = d;
    @(negedge clk);
    start_v[i] = 1'b0;
    data_v[i]  = 10'($urandom);
  endtask

  task automatic wait_done(input int i, output int k, output bit busy_ok);
    k = 1;
    busy_ok = 1'b1;
    while (done_v[i] !== 1'b1 && k < 5000) begin
      if (busy_v[i] !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic send_word(input string tag, input int i, input logic [9:0] d, input logic [10:0] exp);
    int k;
    bit bok;
    kick(i, d);
    check({tag, "_accept"}, {29'd0, busy_v[i], sclk_v[i], sdata_v[i]}, {29'd0, 1'b1, 1'b0, d[9]});
    wait_done(i, k, bok);
    check({tag, "_latency"}, k, FRAMES * 2 * DIVS[i] + 1);
    check({tag, "_busy_held"}, {31'd0, bok}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy_v[i]}, 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, {31'd0, done_v[i]}, 32'd0);
    check({tag, "_rx_word"}, {21'd0, last_word[i]}, {21'd0, exp});
    check({tag, "_rises"}, last_rises[i], FRAMES);
    $display("word %s inst=%0d div=%0d data=%03h lat=%0d rx=%03h rises=%0d",
             tag, i, DIVS[i], d, k, last_word[i], last_rises[i]);
  endtask

  typedef struct {
    int         inst;
    logic [9:0] data;
    logic [9:0] exp_word;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int k, n, dc;
    bit bok;
    logic [9:0] d;
    int ii;

    tbl[0]  = '{0, 10'h2A5, 10'b1010100101};
    tbl[1]  = '{0, 10'h000, 10'h000};
    tbl[2]  = '{0, 10'h3FF, 10'h3FF};
    tbl[3]  = '{0, 10'h155, 10'h155};
    tbl[4]  = '{0, 10'h2AA, 10'h2AA};
    tbl[5]  = '{1, 10'h000, 10'h000};
    tbl[6]  = '{1, 10'h3FF, 10'h3FF};
    tbl[7]  = '{1, 10'h155, 10'h155};
    tbl[8]  = '{1, 10'h2AA, 10'h2AA};
    tbl[9]  = '{2, 10'h000, 10'h000};
    tbl[10] = '{2, 10'h3FF, 10'h3FF};
    tbl[11] = '{2, 10'h155, 10'h155};
    tbl[12] = '{2, 10'h2AA, 10'h2AA};

    for (int i = 0; i < NI; i++) begin
      enable_v[i] = 1'b1;
      start_v[i]  = 1'b0;
      data_v[i]   = '0;
    end

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    check("reset_outputs", {28'd0, busy_v[0], done_v[0], sclk_v[0], sdata_v[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", {28'd0, busy_v[0], done_v[0], sclk_v[0], sdata_v[0]}, 32'd0);

    // Table: single word plus loopback words on all three dividers
    for (int t = 0; t < 13; t++)
      send_word($sformatf("tbl%0d", t), tbl[t].inst, tbl[t].data, exp_frame(tbl[t].exp_word));

    // Busy lockout: a start mid-word is ignored
    kick(0, 10'h3FF);
    repeat (7) @(negedge clk);
    start_v[0] = 1'b1;
    data_v[0]  = 10'h001;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_done(0, k, bok);
    check("lockout_latency", k, FRAMES * 2 * DIVS[0] + 1 - 8);
    check("lockout_busy_held", {31'd0, bok}, 32'd1);
    // Back-to-back: start in the done cycle is accepted
    start_v[0] = 1'b1;
    data_v[0]  = 10'h001;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("b2b_accept", {29'd0, busy_v[0], sclk_v[0], sdata_v[0]}, 32'b100);
    check("lockout_rx_word", {21'd0, last_word[0]}, {21'd0, exp_frame(10'h3FF)});
    wait_done(0, k, bok);
    check("b2b_latency", k, FRAMES * 2 * DIVS[0] + 1);
    @(negedge clk);
    check("b2b_rx_word", {21'd0, last_word[0]}, {21'd0, exp_frame(10'h001)});
    $display("word b2b inst=0 data=001 lat=%0d rx=%03h", k, last_word[0]);

    // Abort after 5 rises
    kick(0, 10'h155);
    n = 0;
    while (rises[0] < 5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rise5", {31'd0, n < 500}, 32'd1);
    dc = done_cnt[0];
    enable_v[0] = 1'b0;
    @(negedge clk);
    check("abort_outputs", {28'd0, busy_v[0], done_v[0], sclk_v[0], sdata_v[0]}, 32'd0);
    start_v[0] = 1'b1;
    data_v[0]  = 10'h2AA;
    repeat (3) @(negedge clk);
    check("start_while_disabled", {31'd0, busy_v[0]}, 32'd0);
    start_v[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("abort_no_done", done_cnt[0], dc);
    enable_v[0] = 1'b1;
    @(negedge clk);
    send_word("after_abort", 0, 10'h2C3, exp_frame(10'h2C3));

    // Reset asserted mid-word (during bit 4)
    kick(0, 10'h2AA);
    n = 0;
    while (rises[0] < 4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rst_busy_before", {31'd0, busy_v[0]}, 32'd1);
    dc = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {28'd0, busy_v[0], done_v[0], sclk_v[0], sdata_v[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_no_done", done_cnt[0], dc);
    check("rst_idle", {28'd0, busy_v[0], done_v[0], sclk_v[0], sdata_v[0]}, 32'd0);
    dc = done_cnt[0];

`ifdef SERIAL_TX_PARITY_EN
    send_word("par007", 0, 10'h007, {10'h007, 1'b1});
    send_word("par003", 0, 10'h003, {10'h003, 1'b0});
`endif

    // Randomized words against the receiver model
    for (int r = 0; r < 20; r++) begin
      ii = int'($urandom_range(0, NI - 1));
      d  = 10'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send_word($sformatf("rnd%0d", r), ii, d, exp_frame(d));
    end

    for (int i = 0; i < NI; i++)
      check($sformatf("data_stable_inst%0d", i), viol[i], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
2-wire synchronous serial transmitter for the output operation, i.e. the ASIC-to-microcontroller direction.
- ASIC generates both serial_clk and serial_data from clk; the microcontroller samples serial_data on rising edges of serial_clk.
- Word format matches the input path: 10 bits, MSB first, no start/stop bits, exactly 10 rising edges per word.
- Fed by the core's output-instruction logic through a start/busy/done handshake.

Parameters:
- DATA_W, 10, bits per word; fixed at 10 for protocol compatibility.
- CLK_DIV, 4, clk cycles per serial_clk half-period; legal range 2..255; receiver synchroniser needs at least 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- enable  input  1  transmitter enable; low aborts and holds idle
- start  input  1  request to send data_in; sampled when idle
- data_in  input  10  word to send; latched on accepted start
- busy  output  1  high while a word is in flight
- done  output  1  single-cycle pulse when a word completes
- serial_clk  output  1  serial clock to microcontroller (registered)
- serial_data  output  1  serial data to microcontroller (registered)

Behaviour:
- Reset values: busy=0, done=0, serial_clk=0, serial_data=0. State is IDLE, counters are 0 and the shift register is 0.
- States:
  - IDLE: all outputs low except that done may pulse.
  - LOW: serial_clk=0; serial_data holds the current bit.
  - HIGH: serial_clk=1; serial_data is unchanged.
- Phase counter counts 0..CLK_DIV-1 per phase. The bit counter counts 0..9.
- Accept: in IDLE with enable=1 and start=1 at clock edge N:
  - data_in is latched.
  - From cycle N+1: busy=1, state=LOW, serial_data=data_in[9].
- Bit k is sent as a LOW phase (CLK_DIV cycles) followed by a HIGH phase (CLK_DIV cycles).
- At the end of each HIGH phase, when k<9: shift left, enter LOW, and update serial_data to the next bit in that same cycle. serial_data therefore changes only when serial_clk falls and is stable for CLK_DIV cycles on both sides of every rising edge.
- At the end of HIGH for bit 9, in cycle N+1+20*CLK_DIV:
  - State returns to IDLE.
  - serial_clk=0, serial_data=0, busy=0, done=1.
- done is high for exactly one cycle.
- start while busy=1 is ignored; no queueing.
- start in the done cycle is accepted (state is already IDLE), so back-to-back words are separated by one idle low cycle plus the next LOW phase.
- enable=0 in any state:
  - Next cycle: IDLE, busy=0, serial_clk=0, serial_data=0.
  - No done pulse. The word is dropped; the microcontroller sees fewer than 10 edges and must resynchronise.
- start while enable=0 is ignored.
- data_in changes after acceptance have no effect on the word in flight.
- rst_n assertion mid-word: immediate return to reset values; no glitch-free guarantee on serial_clk during the reset itself.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined:
  - An 11th frame carrying even parity (XOR of the 10 data bits) is sent after bit 9 with identical LOW/HIGH timing.
  - done and the busy fall occur at N+1+22*CLK_DIV.
  - The microcontroller must expect 11 edges.
- Undefined: exactly 10 frames, with no parity logic present.

Test Plan:
- Reset: assert rst_n=0 mid-word (CLK_DIV=2, bit 4) -> all outputs 0 within the reset, IDLE afterwards, no done pulse.
- Single word: CLK_DIV=2, start with data_in=10'h2A5 at edge N.
  - Bits sampled at serial_clk rises = 1,0,1,0,1,0,0,1,0,1.
  - Exactly 10 rises.
  - busy high N+1..N+40; done=1 only at N+41.
- Busy lockout and back-to-back: start 10'h3FF, then start 10'h001 while busy -> second start ignored. Re-issuing 10'h001 in the done cycle -> accepted, serial_data=0 from the following cycle.
- Abort: enable dropped after 5 serial_clk rises -> next cycle serial_clk=0, serial_data=0, busy=0, done never pulses. A new start after enable returns sends the full word.
- Loopback: connect to serial_rx (same clk, CLK_DIV=2, 3, 8), send 10'h000, 10'h3FF, 10'h155, 10'h2AA -> receiver done with data_out equal to each sent word.
- SERIAL_TX_PARITY_EN defined: send 10'h007 -> 11th sampled bit=1, done at N+1+22*CLK_DIV. Send 10'h003 -> 11th bit=0.
